// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one pipeline stage with valid/ready handshakes on both sides.
//
// Entries are kept in order. M is the entry shown to the downstream side. When
// SKID_EN=1 there is also a second slot S. This lets up_ready_out be a pure
// function of registered state, so there is no combinational path from
// dn_ready_in. When SKID_EN=0 the stage holds one entry, and ready looks ahead
// at dn_ready_in.
//
// Ports:
//   clk_in          clock, rising edge
//   rst_in          synchronous active-high reset
//   rdy_in          global enable; low freezes state and blocks transfers
//   flush_in        discard all held entries
//   up_valid_in     upstream offers up_data_in
//   up_data_in      upstream payload
//   up_ready_out    stage can accept an entry this cycle
//   dn_valid_out    stage presents dn_data_out
//   dn_data_out     presented payload, NOP_VAL when empty
//   dn_ready_in     downstream accepts the presented entry
//   occ_out         number of held entries (0..2)
//   bubble_cnt_out  saturating count of cycles where downstream was ready but starved
module pipe_skid_stage #(
    parameter int unsigned       DATA_W  = 110,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter bit                SKID_EN = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              up_valid_in,
    input  logic [DATA_W-1:0] up_data_in,
    output logic              up_ready_out,
    output logic              dn_valid_out,
    output logic [DATA_W-1:0] dn_data_out,
    input  logic              dn_ready_in,
    output logic [1:0]        occ_out,
    output logic [15:0]       bubble_cnt_out
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [15:0]       bubble_cnt_q, bubble_cnt_d;
    logic              push, pop;

    always_comb begin
        if (SKID_EN) begin
            up_ready_out = !s_valid_q && !rst_in;
        end else begin
            up_ready_out = (!m_valid_q || dn_ready_in) && !rst_in;
        end
    end

    assign push = up_valid_in && up_ready_out && rdy_in && !flush_in;
    assign pop  = m_valid_q && dn_ready_in && rdy_in && !flush_in;

    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        s_valid_d    = s_valid_q;
        s_data_d     = s_data_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_in) begin
            // Flush does not depend on rdy_in.
            m_valid_d = 1'b0;
            m_data_d  = NOP_VAL;
            s_valid_d = 1'b0;
            s_data_d  = NOP_VAL;
        end else if (rdy_in) begin
            case ({push, pop})
                2'b10: begin
                    if (!m_valid_q) begin
                        m_valid_d = 1'b1;
                        m_data_d  = up_data_in;
                    end else if (SKID_EN) begin
                        s_valid_d = 1'b1;
                        s_data_d  = up_data_in;
                    end
                end
                2'b01: begin
                    if (s_valid_q) begin
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                        s_data_d  = NOP_VAL;
                    end else begin
                        m_valid_d = 1'b0;
                        m_data_d  = NOP_VAL;
                    end
                end
                // A push can only happen with S empty, so the new entry replaces M directly.
                2'b11: m_data_d = up_data_in;
                default: ;
            endcase
        end

        // The bubble count ignores flush_in. It is gated only by the global enable.
        if (rdy_in && dn_ready_in && !m_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= NOP_VAL;
            s_valid_q    <= 1'b0;
            s_data_q     <= NOP_VAL;
            bubble_cnt_q <= 16'd0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign dn_valid_out   = m_valid_q;
    assign dn_data_out    = m_valid_q ? m_data_q : NOP_VAL;
    assign occ_out        = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign bubble_cnt_out = bubble_cnt_q;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
- REQ-001 Parameter DATA_W, default 110, width of the payload carried through the stage.
- REQ-002 Parameter NOP_VAL, default all-zero DATA_W vector, value driven on dn_data_out when the stage holds no valid entry.
- REQ-003 Parameter SKID_EN, default 1; 1 = two-entry skid stage with registered ready, 0 = single-entry stage with combinational ready.
- REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
- REQ-005 rst_in  input  1  reset; synchronous, active-high.
- REQ-006 rdy_in  input  1  global enable; low freezes all state and blocks all transfers.
- REQ-007 flush_in  input  1  synchronous discard of all held entries.
- REQ-008 up_valid_in  input  1  upstream offers an entry.
- REQ-009 up_data_in  input  DATA_W  upstream payload.
- REQ-010 up_ready_out  output  1  stage can accept an entry this cycle.
- REQ-011 dn_valid_out  output  1  stage presents a valid entry.
- REQ-012 dn_data_out  output  DATA_W  presented payload, NOP_VAL when not valid.
- REQ-013 dn_ready_in  input  1  downstream accepts the presented entry.
- REQ-014 occ_out  output  2  number of held entries, 0..2.
- REQ-015 bubble_cnt_out  output  16  count of downstream bubble cycles.

Function
- REQ-016 Push = up_valid_in & up_ready_out & rdy_in & !flush_in; pop = dn_valid_out & dn_ready_in & rdy_in & !flush_in.
- REQ-017 Storage: main entry M (drives dn outputs) and, when SKID_EN=1, skid entry S; order preserved, FIFO semantics.
- REQ-018 SKID_EN=1: up_ready_out = !S_valid & !rst_in, depending only on registered state; no combinational path from dn_ready_in.
- REQ-019 SKID_EN=0: up_ready_out = (!M_valid | dn_ready_in) & !rst_in; S is absent, occ_out never exceeds 1.
- REQ-020 Latency: a push into an empty stage makes dn_valid_out=1 with that payload on the next cycle.
- REQ-021 occ=0, push: entry goes to M.
- REQ-022 occ=1, push without pop: entry goes to S (SKID_EN=1).
- REQ-023 occ=1, push with pop: entry replaces M; occ stays 1.
- REQ-024 occ=2, pop: S moves to M, S cleared; no push possible (ready low).
- REQ-025 pop without push: occ decrements; at occ=1, M becomes invalid and dn_data_out returns to NOP_VAL.
- REQ-026 dn_data_out = M_data when M_valid, else NOP_VAL; held entries never change while dn_ready_in is low.
- REQ-027 rdy_in=0: M, S, occ_out and bubble_cnt_out hold; up_ready_out still reflects state, but no transfer completes.
- REQ-028 flush_in=1: next cycle M_valid=S_valid=0, occ_out=0 and dn_data_out=NOP_VAL, regardless of rdy_in; a concurrent push is dropped.
- REQ-029 bubble_cnt_out increments when rdy_in & dn_ready_in & !dn_valid_out, saturates at 16'hFFFF, and is unaffected by flush_in.
- REQ-030 occ_out = M_valid + S_valid, with no glitch-free requirement beyond registered values.

Reset
- REQ-031 While rst_in=1 at a rising edge: M_valid=S_valid=0, M/S data=NOP_VAL, occ_out=0, bubble_cnt_out=0, dn_valid_out=0, and dn_data_out=NOP_VAL.
- REQ-032 up_ready_out=0 while rst_in=1; it is 1 in the first cycle after rst_in deasserts.
- REQ-033 Reset has priority over flush_in and rdy_in; reset mid-transfer discards all entries without emitting them.

Verification
- REQ-034 Bench: empty stage, push 0x1 with dn_ready_in=1 -> next cycle dn_valid_out=1 and dn_data_out=0x1, occ_out=1.
- REQ-035 Bench (SKID_EN=1): dn_ready_in=0, push 0xA then 0xB -> occ_out=2 and up_ready_out=0; raise dn_ready_in -> outputs 0xA then 0xB on consecutive cycles.
- REQ-036 Bench: occ_out=2, assert flush_in with up_valid_in=1 data 0xC -> next cycle occ_out=0, dn_data_out=NOP_VAL, and 0xC never appears.
- REQ-037 Bench: rdy_in=0 for 5 cycles with up_valid_in=dn_ready_in=1 -> no occ_out change and bubble_cnt_out unchanged.
- REQ-038 Bench: empty stage, dn_ready_in=1, rdy_in=1 for 70000 cycles -> bubble_cnt_out=16'hFFFF; then assert rst_in -> bubble_cnt_out=0.
- REQ-039 Bench (SKID_EN=0): occ_out=1, push 0xD with dn_ready_in=1 -> M=0xD next cycle, occ_out=1.
